// File: rtl/board_input_conditioner.sv
// board_input_conditioner: per-channel synchroniser, debounce, edge detect, sticky pending bits and interrupt
module board_input_conditioner #(
    parameter int NCH = 21,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES = 100000,
    localparam int CNT_W = $clog2(DB_CYCLES + 1)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] i_raw,
    input  logic [NCH-1:0] i_rise_en,
    input  logic [NCH-1:0] i_fall_en,
    input  logic [NCH-1:0] i_mask,
    input  logic [NCH-1:0] i_clr,
    output logic [NCH-1:0] o_level,
    output logic [NCH-1:0] o_rise,
    output logic [NCH-1:0] o_fall,
    output logic [NCH-1:0] o_pending,
    output logic           o_irq
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    logic [NCH-1:0] sync [SYNC_STAGES];
    logic [CNT_W-1:0] cnt [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0] s;
    logic [NCH-1:0] acc;
    logic [NCH-1:0] set;
    assign s = sync[SYNC_STAGES-1];
    assign set = (o_rise & i_rise_en) | (o_fall & i_fall_en);
    // synchroniser chain: pads enter at stage 0, stable copy leaves at the last stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
        end else begin
            sync[0] <= i_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
    end
    // accept a channel once it has disagreed with its level for the full count; any agreement restarts the count
    always_comb begin
        acc = '0;
        for (int i = 0; i < NCH; i++) begin
            acc[i] = (s[i] != o_level[i]) && (cnt[i] == CNT_MAX);
            cnt_d[i] = (s[i] == o_level[i] || acc[i]) ? '0 : cnt[i] + CNT_W'(1);
        end
    end
    // debounce state, edge pulses, sticky pending bits (set beats clear) and registered interrupt
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            o_level <= '0;
            o_rise <= '0;
            o_fall <= '0;
            o_pending <= '0;
            o_irq <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) cnt[i] <= cnt_d[i];
            o_level <= o_level ^ acc;
            o_rise <= acc & s;
            o_fall <= acc & ~s;
            o_pending <= set | (o_pending & ~i_clr);
            o_irq <= |(o_pending & i_mask);
        end
    end
endmodule

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner: directed and randomized checks against a sample-window reference model
module tb_board_input_conditioner;
    localparam int NCH = 4;
    localparam int SYNC = 2;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [NCH-1:0] i_raw = '0, i_rise_en = '0, i_fall_en = '0, i_mask = '0, i_clr = '0;
    logic [NCH-1:0] o_level, o_rise, o_fall, o_pending;
    logic o_irq;
    int checks = 0;
    int failures = 0;

    logic [NCH-1:0] m_sync [SYNC];
    logic [NCH-1:0] m_level, m_rise, m_fall, m_pend;
    logic m_irq;
    logic [NCH-1:0] hist [$];

    always #5 clk = ~clk;

    board_input_conditioner #(.NCH(NCH), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
        .clk(clk), .rstn(rstn), .i_raw(i_raw), .i_rise_en(i_rise_en), .i_fall_en(i_fall_en),
        .i_mask(i_mask), .i_clr(i_clr), .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
        .o_pending(o_pending), .o_irq(o_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
        hist.delete();
    endtask

    // a channel is accepted when its last DB synchronised samples all differ from the current level
    task automatic m_step();
        logic [NCH-1:0] sv, acc;
        bit all;
        sv = m_sync[SYNC-1];
        hist.push_back(sv);
        if (hist.size() > DB) void'(hist.pop_front());
        acc = '0;
        for (int c = 0; c < NCH; c++) begin
            all = (hist.size() == DB);
            foreach (hist[j]) if (hist[j][c] == m_level[c]) all = 0;
            acc[c] = all;
        end
        m_irq = |(m_pend & i_mask);
        m_pend = (m_rise & i_rise_en) | (m_fall & i_fall_en) | (m_pend & ~i_clr);
        m_rise = acc & sv;
        m_fall = acc & ~sv;
        for (int c = 0; c < NCH; c++) if (acc[c]) m_level[c] = sv[c];
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = i_raw;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstn) m_reset(); else m_step();
        #1;
        chk("level", o_level, m_level);
        chk("rise", o_rise, m_rise);
        chk("fall", o_fall, m_fall);
        chk("pending", o_pending, m_pend);
        chk("irq", o_irq, m_irq);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int nr, nf, tr, tf, t;
        m_reset();
        // 1. reset with all inputs high
        i_raw = 4'hF;
        ticks(3);
        chk("rst_level", o_level, 4'h0);
        chk("rst_pending", {o_pending, 3'b0, o_irq}, 0);
        rstn = 1'b1;
        tick();
        chk("release_rise", o_rise, 4'h0);
        nr = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (o_rise == 4'hF) nr++;
        end
        chk("release_level", o_level, 4'hF);
        chk("release_rise_count", nr, 1);
        // 2. step latency on ch0
        i_raw = 4'h0;
        ticks(12);
        chk("fall_settle", o_level, 4'h0);
        i_raw = 4'h1;
        for (int i = 1; i <= 9; i++) tick();
        chk("step_early", o_level[0], 1'b0);
        tick();
        chk("step_level", o_level[0], 1'b1);
        chk("step_rise", o_rise, 4'h1);
        chk("step_nofall", o_fall, 4'h0);
        tick();
        chk("step_rise_end", o_rise, 4'h0);
        // 3. glitch rejection on ch1
        i_raw[1] = 1'b1;
        ticks(7);
        i_raw[1] = 1'b0;
        nr = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (o_rise[1]) nr++;
        end
        chk("glitch_rise", nr, 0);
        chk("glitch_level", o_level[1], 1'b0);
        i_raw[1] = 1'b1;
        ticks(8);
        i_raw[1] = 1'b0;
        nr = 0; nf = 0; tr = 0; tf = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (o_rise[1]) begin nr++; tr = i; end
            if (o_fall[1]) begin nf++; tf = i; end
        end
        chk("pulse8_rise", nr, 1);
        chk("pulse8_fall", nf, 1);
        chk("pulse8_gap", tf - tr, 8);
        // 4. enable and mask
        i_rise_en = 4'b0001; i_fall_en = 4'b0010; i_mask = 4'b0011;
        i_raw[0] = 1'b0;
        ticks(12);
        chk("en_fall0_nopend", o_pending, 4'h0);
        i_raw[0] = 1'b1;
        t = 0;
        for (int i = 0; i < 20 && !o_rise[0]; i++) begin tick(); t++; end
        chk("en_rise0_seen", o_rise[0], 1'b1);
        tick();
        chk("en_pend0", o_pending, 4'b0001);
        chk("en_irq_lag", o_irq, 1'b0);
        tick();
        chk("en_irq", o_irq, 1'b1);
        i_raw[1] = 1'b1;
        ticks(12);
        chk("en_rise1", o_pending, 4'b0001);
        i_raw[1] = 1'b0;
        ticks(12);
        chk("en_fall1", o_pending, 4'b0011);
        // 5. clear versus simultaneous set
        i_raw[0] = 1'b0;
        ticks(12);
        i_raw[0] = 1'b1;
        for (int i = 0; i < 20 && !o_rise[0]; i++) tick();
        chk("clr_rise_seen", o_rise[0], 1'b1);
        i_clr = 4'b0001;
        tick();
        i_clr = 4'h0;
        chk("clr_vs_set", o_pending[0], 1'b1);
        tick();
        i_clr = 4'hF;
        tick();
        i_clr = 4'h0;
        chk("clr_all", o_pending, 4'h0);
        tick();
        chk("clr_irq", o_irq, 1'b0);
        // 6. asynchronous reset mid-count on ch2
        i_raw[2] = 1'b1;
        ticks(4);
        #2 rstn = 1'b0;
        #1 m_reset();
        chk("async_level", o_level, 4'h0);
        chk("async_rest", {o_rise, o_fall, o_pending, 3'b0, o_irq}, 0);
        ticks(2);
        rstn = 1'b1;
        t = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (o_rise[2] && t == 0) t = i;
        end
        chk("async_relatency", t, 10);
        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) if ($urandom_range(11) == 0) i_raw[c] = ~i_raw[c];
            if ($urandom_range(15) == 0) i_rise_en = 4'($urandom);
            if ($urandom_range(15) == 0) i_fall_en = 4'($urandom);
            if ($urandom_range(15) == 0) i_mask = 4'($urandom);
            i_clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/board_input_conditioner.md
# board_input_conditioner

Parametrised input-conditioning block for the board's switches and pushbuttons, placed between the pads and the GPIO/push-button registers in the core clock domain (`clk_core`). Each of `NCH` channels gets a synchroniser, an independent debounce filter, and rise/fall edge detection. Each channel also has a sticky, maskable event-pending bit. The pending bits are OR-reduced into one registered interrupt. This replaces the unconditioned direct wiring of `i_sw` and the buttons with a single generic block covering any channel count.

## Interface

Parameters:
- `NCH`, 21, number of input channels (16 switches + 5 buttons); ≥1.
- `SYNC_STAGES`, 2, flip-flop stages in each synchroniser; ≥2.
- `DB_CYCLES`, 100000, consecutive stable cycles needed to accept a new level; ≥1.
- `CNT_W`, `$clog2(DB_CYCLES+1)`, width of the debounce counter; derived, not overridden.

Ports:
- `clk` in 1: core clock.
- `rstn` in 1: reset, asynchronous and active-low.
- `i_raw` in NCH: asynchronous pad inputs.
- `i_rise_en` in NCH: per channel, a rising edge sets pending.
- `i_fall_en` in NCH: per channel, a falling edge sets pending.
- `i_mask` in NCH: per channel, 1 lets pending contribute to `o_irq`.
- `i_clr` in NCH: write-1-to-clear strobe for the pending bits; one cycle.
- `o_level` out NCH: debounced level.
- `o_rise` out NCH: one-cycle pulse on an accepted 0→1 transition.
- `o_fall` out NCH: one-cycle pulse on an accepted 1→0 transition.
- `o_pending` out NCH: sticky event bits.
- `o_irq` out 1: registered `|(o_pending & i_mask)`.

## Operation

- **Reset.** On `rstn` low, all state clears immediately: synchroniser stages, counters, `o_level`, `o_rise`, `o_fall`, `o_pending` and `o_irq` all go to 0. No edge pulse is produced when reset releases, even if `i_raw` is 1; the first acceptance of a 1 gives a normal `o_rise`.
- **Synchroniser.** Per channel, a chain of `SYNC_STAGES` flops; `s` is the last stage.
- **Debounce counter.** Per channel, counter `cnt`:
  - If `s == o_level`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `o_level <= s` and `cnt <= 0`. On the same edge, `o_rise <= s` and `o_fall <= ~s`.
  - Else: `cnt <= cnt + 1`.
- **Edge pulses.** `o_rise`/`o_fall` are 0 in every cycle with no acceptance. The two are never high together.
- **Glitch rejection.** Any return of `s` to `o_level` before the count completes resets `cnt`. The glitch produces no pulse and no level change.
- **Counter width.** The counter never exceeds `DB_CYCLES-1`, so there is no wrap-around.
- **DB_CYCLES = 1.** Acceptance happens on the first mismatching cycle, i.e. no filtering.
- **Pending bits.** Per channel, the set condition is `set = (o_rise & i_rise_en) | (o_fall & i_fall_en)`.
  - Next value: `pending <= set | (pending & ~i_clr)`.
  - Set wins over a simultaneous clear.
  - Enable bits are sampled in the cycle the pulse is present. Changing an enable never creates or removes an existing pending bit.
- **Mask.** The mask affects `o_irq` only, never `o_pending`.
- **Interrupt.** `o_irq <= |(o_pending & i_mask)`.
- **Independence.** Channels are fully independent. Any number of channels may accept in the same cycle.

## Timing

- **Raw to level.** A `i_raw` change that is sampled at edge k and held gives an `o_level` change, plus the one-cycle `o_rise`/`o_fall`, after edge k+SYNC_STAGES+DB_CYCLES-1. Total latency is SYNC_STAGES+DB_CYCLES cycles.
- **Pending.** `o_pending` is set on the edge after the pulse (1 cycle).
- **Interrupt.** `o_irq` asserts 1 cycle after the pending bit is set. It deasserts 1 cycle after the last unmasked pending bit is cleared, or after its mask bit drops.
- **Clear.** `i_clr` sampled at edge n clears the bit, visible after edge n.
- **Throughput.** One accepted transition per channel per DB_CYCLES cycles at most.
- **Reset mid-count.** Any partial count is discarded.
- **Timing paths.** No combinational path from any input to any output.

## Test plan

Default bench configuration: NCH=4, SYNC_STAGES=2, DB_CYCLES=8.

1. **Reset.** Hold `rstn`=0 with `i_raw`=4'hF, then release. Required: all outputs 0 while in reset and at release. `o_level`=4'hF 10 cycles after release, with a single `o_rise`=4'hF pulse and no pulse at release.
2. **Step latency.** Step `i_raw[0]` 0→1 at edge k. Required: `o_level[0]`=1 and `o_rise[0]` high for exactly one cycle after edge k+9. `o_fall` stays 0.
3. **Glitch.** On ch1, apply a 7-cycle high pulse, then 0. Required: no `o_rise`, `o_level[1]`=0. An 8-cycle pulse gives `o_rise[1]` followed by `o_fall[1]` 8 cycles later.
4. **Enable and mask.** Set `i_rise_en`=4'b0001, `i_fall_en`=4'b0010, `i_mask`=4'b0011. Rise ch0 → `o_pending`=4'b0001, then `o_irq`=1 one cycle later. Rise ch1 → pending unchanged. Fall ch1 → `o_pending`=4'b0011.
5. **Clear versus set.** Pulse `i_clr[0]` in the same cycle as a new `o_rise[0]`. Required: `o_pending[0]` stays 1. A later `i_clr`=4'hF alone gives `o_pending`=0 and `o_irq`=0 one cycle after that.
6. **Reset mid-count.** Assert `rstn`=0 asynchronously mid-count, between clock edges, 4 cycles into a ch2 transition. Required: outputs clear before the next clock edge. After release with `i_raw[2]` held at 1, acceptance takes a full 10 cycles.
